// File: rtl/fg_prog_sequencer_if.sv
// Command handshake between the chip-level programming controller
// and the floating-gate programming sequencer.
interface fg_prog_sequencer_if #(
  parameter int DRAIN_BITS = 5,
  parameter int GATE_BITS  = 2,
  parameter int CNT_W      = 8,
  parameter int PW_W       = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DRAIN_BITS-1:0] cmd_drain;
  logic [GATE_BITS-1:0]  cmd_gate;
  logic [CNT_W-1:0]      cmd_pulses;
  logic [PW_W-1:0]       cmd_width;
  logic                  cmd_mode;

  modport master (
    output cmd_valid,
    output cmd_drain,
    output cmd_gate,
    output cmd_pulses,
    output cmd_width,
    output cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_drain,
    input  cmd_gate,
    input  cmd_pulses,
    input  cmd_width,
    input  cmd_mode,
    output cmd_ready
  );
endinterface

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: setup, pulse burst, recovery.
// Optional FG_PROG_SEQ_TUNNEL_EN: cmd_mode=1 pulses vtun_en, not drain_en.
module fg_prog_sequencer #(
  parameter int DRAIN_BITS    = 5,
  parameter int GATE_BITS     = 2,
  parameter int CNT_W         = 8,
  parameter int PW_W          = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fg_prog_sequencer_if.slave    cmd,
  input  logic                  abort,
  output logic                  prog,
  output logic                  run,
  output logic [DRAIN_BITS-1:0] drain_b,
  output logic                  drain_en,
  output logic [GATE_BITS-1:0]  gate_b,
  output logic                  gate_en,
  output logic                  vtun_en,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      pulse_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_RECOVER
  } state_t;

  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GAP_LD    = 32'(GAP_CYCLES - 1);

  state_t                state_q, state_n;
  logic [31:0]           tmr_q, tmr_n;
  logic [DRAIN_BITS-1:0] drain_q, drain_n;
  logic [GATE_BITS-1:0]  gate_q, gate_n;
  logic [CNT_W-1:0]      pulses_q, pulses_n;
  logic [PW_W-1:0]       width_q, width_n;
  logic                  mode_q, mode_n;
  logic [CNT_W-1:0]      pc_n;
  logic                  ab_n;
  logic [31:0]           pw_ld;

  logic                  prog_n, run_n;
  logic                  den_n, gen_n, ven_n;
  logic                  busy_n, ready_n, done_n;
  logic [DRAIN_BITS-1:0] db_n;
  logic [GATE_BITS-1:0]  gb_n;

  // zero-width pulses are stretched to one cycle
  assign pw_ld = (width_q == '0) ? 32'd0
               : 32'(width_q) - 32'd1;

  // next state, cycle timer, command latch and pulse counting
  always_comb begin
    state_n  = state_q;
    tmr_n    = tmr_q;
    drain_n  = drain_q;
    gate_n   = gate_q;
    pulses_n = pulses_q;
    width_n  = width_q;
    mode_n   = mode_q;
    pc_n     = pulse_count;
    ab_n     = aborted;
    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          drain_n  = cmd.cmd_drain;
          gate_n   = cmd.cmd_gate;
          pulses_n = cmd.cmd_pulses;
          width_n  = cmd.cmd_width;
          mode_n   = cmd.cmd_mode;
          pc_n     = '0;
          ab_n     = 1'b0;
          tmr_n    = SETTLE_LD;
          state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          ab_n    = 1'b1;
          tmr_n   = SETTLE_LD;
          state_n = S_RECOVER;
        end else if (tmr_q == 32'd0) begin
          if (pulses_q == '0) begin
            tmr_n   = SETTLE_LD;
            state_n = S_RECOVER;
          end else begin
            tmr_n   = pw_ld;
            state_n = S_PULSE;
          end
        end else begin
          tmr_n = tmr_q - 32'd1;
        end
      end
      S_PULSE: begin
        if (abort) begin
          ab_n    = 1'b1;
          tmr_n   = SETTLE_LD;
          state_n = S_RECOVER;
        end else if (tmr_q == 32'd0) begin
          pc_n = pulse_count + CNT_W'(1);
          if (pc_n == pulses_q) begin
            tmr_n   = SETTLE_LD;
            state_n = S_RECOVER;
          end else begin
            tmr_n   = GAP_LD;
            state_n = S_GAP;
          end
        end else begin
          tmr_n = tmr_q - 32'd1;
        end
      end
      S_GAP: begin
        if (abort) begin
          ab_n    = 1'b1;
          tmr_n   = SETTLE_LD;
          state_n = S_RECOVER;
        end else if (tmr_q == 32'd0) begin
          tmr_n   = pw_ld;
          state_n = S_PULSE;
        end else begin
          tmr_n = tmr_q - 32'd1;
        end
      end
      S_RECOVER: begin
        if (tmr_q == 32'd0) begin
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr_q - 32'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // output values for the upcoming cycle, decoded from the next state
  always_comb begin
    prog_n  = 1'b0;
    run_n   = 1'b0;
    den_n   = 1'b0;
    gen_n   = 1'b0;
    ven_n   = 1'b0;
    busy_n  = 1'b1;
    ready_n = 1'b0;
    db_n    = drain_n;
    gb_n    = gate_n;
    unique case (state_n)
      S_IDLE: begin
        run_n   = 1'b1;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        db_n    = '0;
        gb_n    = '0;
      end
      S_SETUP, S_GAP: prog_n = 1'b1;
      S_PULSE: begin
        prog_n = 1'b1;
        gen_n  = 1'b1;
`ifdef FG_PROG_SEQ_TUNNEL_EN
        den_n  = ~mode_n;
        ven_n  = mode_n;
`else
        // mode is latched but tunnelling is compiled out
        den_n  = 1'b1;
        ven_n  = 1'b0 & mode_n;
`endif
      end
      S_RECOVER: ;
      default: begin
        run_n   = 1'b1;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        db_n    = '0;
        gb_n    = '0;
      end
    endcase
    done_n = (state_q == S_RECOVER) &&
             (state_n == S_IDLE);
  end

  // state, command latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      drain_q       <= '0;
      gate_q        <= '0;
      pulses_q      <= '0;
      width_q       <= '0;
      mode_q        <= 1'b0;
      pulse_count   <= '0;
      aborted       <= 1'b0;
      prog          <= 1'b0;
      run           <= 1'b1;
      drain_b       <= '0;
      gate_b        <= '0;
      drain_en      <= 1'b0;
      gate_en       <= 1'b0;
      vtun_en       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state_q       <= state_n;
      tmr_q         <= tmr_n;
      drain_q       <= drain_n;
      gate_q        <= gate_n;
      pulses_q      <= pulses_n;
      width_q       <= width_n;
      mode_q        <= mode_n;
      pulse_count   <= pc_n;
      aborted       <= ab_n;
      prog          <= prog_n;
      run           <= run_n;
      drain_b       <= db_n;
      gate_b        <= gb_n;
      drain_en      <= den_n;
      gate_en       <= gen_n;
      vtun_en       <= ven_n;
      busy          <= busy_n;
      done          <= done_n;
      cmd.cmd_ready <= ready_n;
    end
  end

endmodule

// File: doc/fg_prog_sequencer.md
# fg_prog_sequencer

Digital sequencer that drives the floating-gate programming path of an analog island: the drain-select address and enable, the gate-select address and enable, and the PROG/RUN mode lines. It accepts one programming command per handshake and performs a timed setup, a burst of injection pulses on the addressed floating-gate element, and a recovery phase. It generalises the fixed 5-bit drain / 2-bit gate decoder wiring of the single-column TA2Cell low-pass-filter island to arbitrary island sizes. It sits between the chip-level programming controller and the island's drain and gate decoder tiles.

## Interface
- DRAIN_BITS, 5, drain decoder address width (rows)
- GATE_BITS, 2, gate decoder address width (columns)
- CNT_W, 8, pulse-count width
- PW_W, 16, pulse-width counter width
- SETTLE_CYCLES, 8, PROG-entry and RUN-return settle time, ≥1
- GAP_CYCLES, 4, enables-low gap between consecutive pulses, ≥1

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_drain  in  DRAIN_BITS  drain (row) address
- cmd_gate  in  GATE_BITS  gate (column) address
- cmd_pulses  in  CNT_W  number of pulses
- cmd_width  in  PW_W  pulse width in cycles
- cmd_mode  in  1  0 = inject, 1 = tunnel (see Configuration)
- abort  in  1  terminate current command
- prog  out  1  PROG mode line
- run  out  1  RUN mode line
- drain_b  out  DRAIN_BITS  drain decoder address
- drain_en  out  1  drain decoder enable
- gate_b  out  GATE_BITS  gate decoder address
- gate_en  out  1  gate decoder enable
- vtun_en  out  1  tunnelling enable
- busy  out  1  command in progress
- done  out  1  one-cycle completion strobe
- aborted  out  1  last command ended by abort; held until next accept
- pulse_count  out  CNT_W  pulses completed for current/last command

## Operation
- States: IDLE, SETUP, PULSE, GAP, RECOVER. All outputs registered.
- Reset values: state IDLE; prog=0, run=1, drain_b=0, gate_b=0, drain_en=0, gate_en=0, vtun_en=0, busy=0, done=0, aborted=0, pulse_count=0, cmd_ready=1.
- IDLE: cmd_ready=1, run=1. On cmd_valid&&cmd_ready: latch drain/gate/pulses/width/mode, clear pulse_count and aborted, go SETUP.
- SETUP: prog=1, run=0, drain_b/gate_b driven with latched address, enables low, SETTLE_CYCLES cycles. Then PULSE, or RECOVER if cmd_pulses==0.
- PULSE: drain_en=gate_en=1 for max(cmd_width,1) cycles; on exit pulse_count+1. If pulse_count reaches cmd_pulses, RECOVER, else GAP.
- GAP: enables low, GAP_CYCLES cycles, back to PULSE.
- RECOVER: enables low, prog=0, run=0, SETTLE_CYCLES cycles, then IDLE with done=1 for one cycle and run=1.
- abort (sampled in SETUP/PULSE/GAP): next cycle enables low, state RECOVER (full SETTLE_CYCLES), aborted=1 set. abort in IDLE/RECOVER ignored.
- cmd_valid while busy ignored (cmd_ready=0); no queuing.
- Addresses held stable from SETUP through RECOVER; return to 0 in IDLE.
- prog and run never simultaneously 1.

## Timing
- Accept at edge k: busy, prog=1, cmd_ready=0 from cycle k+1.
- Busy duration = 2·SETTLE_CYCLES + N·W + (N−1)·GAP_CYCLES (N=cmd_pulses, W=max(cmd_width,1); N=0 gives 2·SETTLE_CYCLES).
- done and run=1 in the first IDLE cycle after busy falls; cmd_ready=1 same cycle; a back-to-back command accepted that cycle.
- Abort at edge a: enables low from a+1; done at a+1+SETTLE_CYCLES.
- rst_n low mid-operation: all outputs to reset values immediately, no RECOVER phase.
- pulse_count saturates at cmd_pulses; no wrap.

## Configuration
- FG_PROG_SEQ_TUNNEL_EN defined: cmd_mode=1 drives vtun_en=1 instead of drain_en during PULSE (gate_en still asserted); cmd_mode=0 unchanged.
- Undefined: cmd_mode ignored, vtun_en constant 0, all commands run as inject.

## Test plan
- Reset: rst_n low → run=1, prog=0, all enables 0, cmd_ready=1, pulse_count=0.
- Defaults, cmd drain=19, gate=2, pulses=3, width=10 → drain_b=19, gate_b=2, busy 54 cycles, three 10-cycle drain_en/gate_en windows 4 cycles apart, done one cycle, pulse_count=3.
- pulses=0, width=10 → busy 16 cycles, drain_en never high, done, pulse_count=0; width=0, pulses=2 → two 1-cycle pulses, busy 22 cycles.
- abort during 2nd pulse of 5 → enables low next cycle, done 9 cycles after abort, aborted=1, pulse_count=1.
- cmd_valid held during busy with different address → ignored; accepted in done cycle, new command starts next cycle.
- With FG_PROG_SEQ_TUNNEL_EN, cmd_mode=1, pulses=1, width=5 → vtun_en and gate_en high 5 cycles, drain_en 0; without macro → drain_en high, vtun_en 0.
